// File: rtl/speed_meter_if.sv
// speed_meter_if: reed input and speed result bundle between the wheel sensor front end and its consumers
interface speed_meter_if #(parameter int WIDTH = 12);
    logic             reed;
    logic [WIDTH-1:0] speed;
    logic             valid;
    logic             busy;
    modport master (output reed, input speed, valid, busy);
    modport slave (input reed, output speed, valid, busy);
endinterface

// File: rtl/speed_meter.sv
// speed_meter: times reed-pulse intervals and divides K by the period to produce speed in 0.1 km/h
module speed_meter #(
    parameter int WIDTH      = 12,
    parameter int PW         = 16,
    parameter int KW         = 24,
    parameter int K          = 75600,
    parameter int MIN_PERIOD = 32,
    parameter int TIMEOUT    = 4000
) (
    input logic         clk,
    input logic         r,
    speed_meter_if.slave bus
);
    localparam int IW = $clog2(KW);
    localparam logic [KW-1:0] KV = KW'(K);
    localparam logic [KW-1:0] SMAX = KW'((1 << WIDTH) - 1);
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    state_t state_q, state_d;
    logic s1_q, s2_q, s3_q;
    logic [PW-1:0] cnt_q, cnt_d, per_q, per_d;
    logic armed_q, armed_d;
    logic [PW:0] rem_q, rem_d;
    logic [KW-1:0] quo_q, quo_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] speed_q, speed_d;
    logic valid_q, valid_d;
    logic strobe, accept, restart, ge;
    logic [PW+1:0] r_sh;
    always_comb begin
        strobe  = s2_q & ~s3_q;
        accept  = strobe & armed_q & (cnt_q >= PW'(MIN_PERIOD));
        restart = strobe & (~armed_q | accept);
        r_sh    = {rem_q, KV[idx_q]};
        ge      = r_sh >= {2'b0, per_q};
        state_d = state_q;
        cnt_d   = restart ? PW'(1) : (&cnt_q ? cnt_q : cnt_q + PW'(1));
        per_d   = accept ? cnt_q : per_q;
        armed_d = armed_q | strobe;
        rem_d   = rem_q;
        quo_d   = quo_q;
        idx_d   = idx_q;
        speed_d = speed_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DIV;
                    rem_d   = '0;
                    quo_d   = '0;
                    idx_d   = IW'(KW - 1);
                end else if (armed_q && cnt_q == PW'(TIMEOUT)) begin
                    speed_d = '0;
                    valid_d = 1'b1;
                    armed_d = 1'b0;
                end
            end
            DIV: begin
                rem_d        = ge ? (PW+1)'(r_sh - {2'b0, per_q}) : r_sh[PW:0];
                quo_d[idx_q] = ge;
                idx_d        = idx_q - IW'(1);
                // result is registered on the last iteration so it is visible during DONE
                if (idx_q == '0) begin
                    state_d = DONE;
                    speed_d = (quo_d > SMAX) ? '1 : quo_d[WIDTH-1:0];
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!r) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= '0;
            per_q   <= '0;
            armed_q <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            idx_q   <= '0;
            speed_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= bus.reed;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            armed_q <= armed_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            idx_q   <= idx_d;
            speed_q <= speed_d;
            valid_q <= valid_d;
        end
    end
    assign bus.speed = speed_q;
    assign bus.valid = valid_q;
    assign bus.busy  = state_q != IDLE;
endmodule

// File: tb/tb_speed_meter.sv
// tb_speed_meter: directed and randomized checks of speed_meter against an event-level reference model
module tb_speed_meter;
    localparam int KW = 24, K = 75600, MINP = 32, TO = 4000, SMAX = 4095;
    typedef struct {int cyc; int spd;} ev_t;
    logic clk = 1'b0;
    logic r = 1'b0;
    speed_meter_if #(.WIDTH(12)) a_if ();
    speed_meter_if #(.WIDTH(12)) b_if ();
    speed_meter u_a (.clk(clk), .r(r), .bus(a_if.slave));
    speed_meter #(.K(200000)) u_b (.clk(clk), .r(r), .bus(b_if.slave));
    int n_tests = 0, n_fail = 0, cyc = 0, busy_cnt = 0, rule_err = 0;
    ev_t act_q[$], exp_q[$];
    int edges_q[$];
    logic pv;
    logic [11:0] ps;
    bit skip = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // records every valid strobe and checks the output-stability rules each cycle
    always @(negedge clk) begin
        if (!r) skip = 1'b1;
        else begin
            ev_t e;
            if (a_if.busy) busy_cnt++;
            if (a_if.valid) begin
                e.cyc = cyc;
                e.spd = int'(a_if.speed);
                act_q.push_back(e);
            end
            if (!skip && a_if.valid && pv) rule_err++;
            if (!skip && !a_if.valid && a_if.speed !== ps) rule_err++;
            skip = 1'b0;
        end
        pv = a_if.valid;
        ps = a_if.speed;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reed(input logic v);
        a_if.reed = v;
        b_if.reed = v;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    // raises reed so that the edge strobe lands in cycle s
    task automatic rise_at(input int s);
        wait_to(s - 2);
        set_reed(1'b1);
        repeat (3) step();
        set_reed(1'b0);
    endtask

    task automatic do_reset();
        r = 1'b0;
        set_reed(1'b0);
        step();
        step();
        r = 1'b1;
        act_q.delete();
        busy_cnt = 0;
    endtask

    function automatic void build_exp(input int end_c);
        bit armed;
        int start;
        ev_t e;
        armed = 1'b0;
        start = 0;
        exp_q.delete();
        foreach (edges_q[i]) begin
            int t;
            t = edges_q[i];
            if (armed && t > start + TO) begin
                e.cyc = start + TO + 1;
                e.spd = 0;
                exp_q.push_back(e);
                armed = 1'b0;
            end
            if (!armed) begin
                armed = 1'b1;
                start = t;
            end else if (t - start >= MINP) begin
                e.cyc = t + KW + 1;
                e.spd = (K / (t - start) > SMAX) ? SMAX : K / (t - start);
                exp_q.push_back(e);
                start = t;
            end
        end
        if (armed && start + TO + 1 <= end_c) begin
            e.cyc = start + TO + 1;
            e.spd = 0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic test_reset();
        r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_reed(logic'(i % 2 == 0));
            step();
            n_tests++;
            if ({a_if.speed, a_if.valid, a_if.busy} !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: speed=%0d valid=%b busy=%b, want 0 0 0", i, a_if.speed, a_if.valid, a_if.busy);
            end
        end
        set_reed(1'b0);
        r = 1'b1;
        act_q.delete();
        repeat (50) step();
        n_tests++;
        if (act_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: %0d valid strobes after release, want 0", act_q.size());
        end
    endtask

    task automatic test_basic();
        int s0;
        do_reset();
        s0 = cyc + 5;
        rise_at(s0);
        rise_at(s0 + 100);
        wait_to(s0 + 100 + KW + 6);
        n_tests++;
        if (act_q.size() != 1) begin
            n_fail++;
            $display("FAIL basic_count: %0d valid strobes, want 1", act_q.size());
        end
        if (act_q.size() > 0) begin
            n_tests++;
            if (act_q[0].cyc != s0 + 125 || act_q[0].spd != 756) begin
                n_fail++;
                $display("FAIL basic_result: cycle %0d speed %0d, want cycle %0d speed 756", act_q[0].cyc, act_q[0].spd, s0 + 125);
            end
        end
        n_tests++;
        if (busy_cnt != KW + 1) begin
            n_fail++;
            $display("FAIL basic_busy: busy for %0d cycles, want %0d", busy_cnt, KW + 1);
        end
        n_tests++;
        if (a_if.speed !== 12'd756) begin
            n_fail++;
            $display("FAIL basic_hold: speed=%0d, want 756", a_if.speed);
        end
    endtask

    task automatic test_bounce();
        int s0;
        do_reset();
        s0 = cyc + 5;
        rise_at(s0);
        rise_at(s0 + 10);
        rise_at(s0 + 200);
        wait_to(s0 + 200 + KW + 6);
        n_tests++;
        if (act_q.size() != 1 || act_q[0].cyc != s0 + 225 || act_q[0].spd != 378) begin
            n_fail++;
            $display("FAIL bounce: %0d strobes, first speed %0d, want 1 strobe speed 378 at %0d", act_q.size(), a_if.speed, s0 + 225);
        end
    endtask

    task automatic test_min_period();
        int s0;
        do_reset();
        s0 = cyc + 5;
        rise_at(s0);
        rise_at(s0 + 32);
        rise_at(s0 + 63);
        rise_at(s0 + 95);
        wait_to(s0 + 95 + KW + 6);
        n_tests++;
        if (act_q.size() != 2) begin
            n_fail++;
            $display("FAIL minp_count: %0d strobes, want 2", act_q.size());
        end else begin
            n_tests++;
            if (act_q[0].spd != 2362 || act_q[0].cyc != s0 + 57) begin
                n_fail++;
                $display("FAIL minp_exact: speed %0d at %0d, want 2362 at %0d", act_q[0].spd, act_q[0].cyc, s0 + 57);
            end
            n_tests++;
            if (act_q[1].spd != 1200 || act_q[1].cyc != s0 + 120) begin
                n_fail++;
                $display("FAIL minp_below: speed %0d at %0d, want 1200 at %0d", act_q[1].spd, act_q[1].cyc, s0 + 120);
            end
        end
    endtask

    task automatic test_saturation();
        int s0;
        do_reset();
        s0 = cyc + 5;
        rise_at(s0);
        rise_at(s0 + 40);
        wait_to(s0 + 40 + KW + 6);
        n_tests++;
        if (b_if.speed !== 12'd4095) begin
            n_fail++;
            $display("FAIL saturate: speed=%0d, want 4095", b_if.speed);
        end
        n_tests++;
        if (act_q.size() != 1 || a_if.speed !== 12'd1890) begin
            n_fail++;
            $display("FAIL sat_ref: %0d strobes speed=%0d, want 1 strobe speed 1890", act_q.size(), a_if.speed);
        end
    endtask

    task automatic test_timeout();
        int s0, s1;
        do_reset();
        s0 = cyc + 5;
        rise_at(s0);
        rise_at(s0 + 100);
        wait_to(s0 + 100 + TO + 21);
        n_tests++;
        if (act_q.size() != 2) begin
            n_fail++;
            $display("FAIL timeout_count: %0d strobes, want 2", act_q.size());
        end else begin
            n_tests++;
            if (act_q[1].cyc != s0 + 100 + TO + 1 || act_q[1].spd != 0) begin
                n_fail++;
                $display("FAIL timeout_event: speed %0d at %0d, want 0 at %0d", act_q[1].spd, act_q[1].cyc, s0 + 100 + TO + 1);
            end
        end
        s1 = cyc + 5;
        rise_at(s1);
        rise_at(s1 + 150);
        wait_to(s1 + 150 + KW + 6);
        n_tests++;
        if (act_q.size() != 3 || act_q[act_q.size()-1].spd != 504 || act_q[act_q.size()-1].cyc != s1 + 175) begin
            n_fail++;
            $display("FAIL rearm: %0d strobes speed=%0d, want 3 strobes ending with 504 at %0d", act_q.size(), a_if.speed, s1 + 175);
        end
    endtask

    task automatic test_reset_mid();
        int s0, s2, s3, n;
        do_reset();
        s0 = cyc + 5;
        rise_at(s0);
        rise_at(s0 + 100);
        s2 = s0 + 400;
        rise_at(s2);
        wait_to(s2 + 10);
        r = 1'b0;
        step();
        r = 1'b1;
        n_tests++;
        if (a_if.busy !== 1'b0 || a_if.speed !== 12'd0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b speed=%0d, want 0 0", a_if.busy, a_if.speed);
        end
        n = act_q.size();
        repeat (40) step();
        n_tests++;
        if (act_q.size() != n || n != 1) begin
            n_fail++;
            $display("FAIL mid_abort: %0d strobes before, %0d after, want 1 and 1", n, act_q.size());
        end
        s3 = cyc + 5;
        rise_at(s3);
        wait_to(s3 + 40);
        n_tests++;
        if (act_q.size() != 1) begin
            n_fail++;
            $display("FAIL mid_arm: %0d strobes, want 1", act_q.size());
        end
        rise_at(s3 + 300);
        wait_to(s3 + 300 + KW + 6);
        n_tests++;
        if (act_q.size() != 2 || a_if.speed !== 12'd252) begin
            n_fail++;
            $display("FAIL mid_resume: %0d strobes speed=%0d, want 2 strobes speed 252", act_q.size(), a_if.speed);
        end
    endtask

    task automatic test_random();
        int t, g, p, end_c;
        do_reset();
        edges_q.delete();
        rule_err = 0;
        t = cyc + 5;
        for (int i = 0; i < 40; i++) begin
            rise_at(t);
            edges_q.push_back(t);
            p = $urandom_range(0, 99);
            g = (p < 25) ? $urandom_range(8, 31) : (p < 90) ? $urandom_range(32, 800) : $urandom_range(3990, 4010);
            t += g;
        end
        end_c = edges_q[edges_q.size()-1] + TO + 30;
        wait_to(end_c);
        build_exp(end_c);
        n_tests++;
        if (act_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: %0d strobes, want %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (act_q[i].cyc != exp_q[i].cyc || act_q[i].spd != exp_q[i].spd) begin
                n_fail++;
                $display("FAIL rand_event[%0d]: speed %0d at %0d, want %0d at %0d", i, act_q[i].spd, act_q[i].cyc, exp_q[i].spd, exp_q[i].cyc);
            end
        end
        n_tests++;
        if (rule_err != 0) begin
            n_fail++;
            $display("FAIL output_rules: %0d violations of valid/speed stability, want 0", rule_err);
        end
    endtask

    initial begin
        set_reed(1'b0);
        test_reset();
        test_basic();
        test_bounce();
        test_min_period();
        test_saturation();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
